// File: rtl/core.sv
// Shared core definitions for the register-file write-port arbiter:
// datapath widths, load-queue/starvation defaults, the queued write request
// record and the starvation FSM state type.
package core;

  localparam int REG_WIDTH     = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int LQ_DEPTH      = 4;
  localparam int STARVE_LIMIT  = 8;

  // One pending register-file write; valid=0 means the write must be dropped.
  typedef struct packed {
    logic                     valid;
    logic [RF_ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]     val;
  } RfWrReq;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } starve_state_e;

endpackage

// File: rtl/rf_wr_ldq.sv
// Load-return queue: circular buffer of RfWrReq entries with extended
// pointers (MSB distinguishes full from empty) and a parallel address-match
// kill that clears the valid bit of every occupied entry, and of an entry
// being pushed in the same cycle, that targets the killed register.
module rf_wr_ldq
  import core::*;
#(
  parameter int DEPTH = LQ_DEPTH,
  localparam int KCW  = $clog2(DEPTH + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_en,
  input  RfWrReq                   push_req,
  input  logic                     pop_en,
  input  logic                     kill_en,
  input  logic [RF_ADDR_WIDTH-1:0] kill_addr,
  output RfWrReq                   head,
  output logic                     full,
  output logic                     empty,
  output logic [KCW-1:0]           kill_cnt
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  RfWrReq          entries_q [DEPTH];
  RfWrReq          entries_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   count;
  logic [IW-1:0]   offset;
  logic            occupied;
  logic            do_push;
  logic            do_pop;
  RfWrReq          push_entry;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign head    = entries_q[rd_ptr_q[IW-1:0]];
  assign do_push = push_en && !full;
  assign do_pop  = pop_en && !empty;

  // Next queue contents: kill matching entries, then push and pop.
  always_comb begin
    entries_d  = entries_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    kill_cnt   = '0;
    offset     = '0;
    occupied   = 1'b0;
    push_entry = push_req;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = IW'(i) - rd_ptr_q[IW-1:0];
      occupied = ({1'b0, offset} < count);
      if (kill_en && occupied && entries_q[i].valid &&
          (entries_q[i].addr == kill_addr)) begin
        entries_d[i].valid = 1'b0;
        kill_cnt           = kill_cnt + KCW'(1);
      end
    end
    if (do_push) begin
      if (kill_en && push_req.valid && (push_req.addr == kill_addr)) begin
        push_entry.valid = 1'b0;
        kill_cnt         = kill_cnt + KCW'(1);
      end
      entries_d[wr_ptr_q[IW-1:0]] = push_entry;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Queue state registers; reset empties the queue and clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule

// File: rtl/rf_wr_port_arbiter.sv
// Register-file write-port arbiter. Writeback always owns the port; load
// returns queue up in rf_wr_ldq and drain into cycles Writeback leaves idle.
// A RUN/STALL FSM raises stall_req after STARVE_LIMIT blocked cycles.
// Optional macro RF_WR_ARB_STATS_EN adds saturating conflict/kill counters.
// The queued RfWrReq record is sized by the core package widths, so
// REG_WIDTH/RF_ADDR_WIDTH should stay at their package defaults.
module rf_wr_port_arbiter
  import core::*;
#(
  parameter int REG_WIDTH     = core::REG_WIDTH,
  parameter int RF_ADDR_WIDTH = core::RF_ADDR_WIDTH,
  parameter int LQ_DEPTH      = core::LQ_DEPTH,
  parameter int STARVE_LIMIT  = core::STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_wr_en,
  input  logic [RF_ADDR_WIDTH-1:0] wb_wr_addr,
  input  logic [REG_WIDTH-1:0]     wb_wr_val,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [RF_ADDR_WIDTH-1:0] ld_addr,
  input  logic [REG_WIDTH-1:0]     ld_val,
  output logic                     rf_wr_en,
  output logic [RF_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [REG_WIDTH-1:0]     rf_wr_val,
  output logic                     stall_req
`ifdef RF_WR_ARB_STATS_EN
  ,
  output logic [31:0]              stat_conflicts,
  output logic [31:0]              stat_kills
`endif
);

  localparam int KCW = $clog2(LQ_DEPTH + 2);
  localparam int CW  = $clog2(STARVE_LIMIT + 1);

  RfWrReq                   push_req;
  RfWrReq                   head;
  logic                     ld_full;
  logic                     ld_empty;
  logic                     push_en;
  logic                     pop_en;
  logic [KCW-1:0]           kill_cnt;

  logic                     rf_wr_en_q, rf_wr_en_d;
  logic [RF_ADDR_WIDTH-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [REG_WIDTH-1:0]     rf_wr_val_q, rf_wr_val_d;
  logic                     stall_req_q, stall_req_d;
  starve_state_e            state_q, state_d;
  logic [CW-1:0]            starve_cnt_q, starve_cnt_d;

  assign ld_ready       = !ld_full && !rst;
  assign push_en        = ld_valid && ld_ready;
  assign pop_en         = !wb_wr_en && !ld_empty;
  assign push_req.valid = (ld_addr != '0);
  assign push_req.addr  = ld_addr;
  assign push_req.val   = ld_val;

  rf_wr_ldq #(
    .DEPTH(LQ_DEPTH)
  ) u_ldq (
    .clk      (clk),
    .rst      (rst),
    .push_en  (push_en),
    .push_req (push_req),
    .pop_en   (pop_en),
    .kill_en  (wb_wr_en),
    .kill_addr(wb_wr_addr),
    .head     (head),
    .full     (ld_full),
    .empty    (ld_empty),
    .kill_cnt (kill_cnt)
  );

  // Port arbitration: Writeback first, else the queue head, else hold.
  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_val_d  = rf_wr_val_q;
    if (wb_wr_en) begin
      rf_wr_en_d   = (wb_wr_addr != '0);
      rf_wr_addr_d = wb_wr_addr;
      rf_wr_val_d  = wb_wr_val;
    end else if (pop_en) begin
      rf_wr_en_d   = head.valid;
      rf_wr_addr_d = head.addr;
      rf_wr_val_d  = head.val;
    end
  end

  // Starvation FSM: count blocked cycles in RUN, hold STALL until drained.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      RUN: begin
        if (pop_en || ld_empty) begin
          starve_cnt_d = '0;
        end else if (wb_wr_en && (starve_cnt_q < CW'(STARVE_LIMIT))) begin
          starve_cnt_d = starve_cnt_q + CW'(1);
        end
        if (starve_cnt_q >= CW'(STARVE_LIMIT)) begin
          state_d      = STALL;
          starve_cnt_d = '0;
        end
      end
      STALL: begin
        starve_cnt_d = '0;
        if (ld_empty) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d      = RUN;
        starve_cnt_d = '0;
      end
    endcase
    stall_req_d = (state_d == STALL);
  end

  // Output and FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_val_q  <= '0;
      stall_req_q  <= 1'b0;
      state_q      <= RUN;
      starve_cnt_q <= '0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_val_q  <= rf_wr_val_d;
      stall_req_q  <= stall_req_d;
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_val  = rf_wr_val_q;
  assign stall_req  = stall_req_q;

`ifdef RF_WR_ARB_STATS_EN
  logic [31:0] stat_conflicts_q, stat_conflicts_d;
  logic [31:0] stat_kills_q, stat_kills_d;
  logic [32:0] kills_sum;

  // Saturating counters for port conflicts and killed queue entries.
  always_comb begin
    stat_conflicts_d = stat_conflicts_q;
    if (wb_wr_en && !ld_empty && (stat_conflicts_q != '1)) begin
      stat_conflicts_d = stat_conflicts_q + 32'd1;
    end
    kills_sum    = {1'b0, stat_kills_q} + 33'(kill_cnt);
    stat_kills_d = kills_sum[32] ? '1 : kills_sum[31:0];
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_conflicts_q <= '0;
      stat_kills_q     <= '0;
    end else begin
      stat_conflicts_q <= stat_conflicts_d;
      stat_kills_q     <= stat_kills_d;
    end
  end

  assign stat_conflicts = stat_conflicts_q;
  assign stat_kills     = stat_kills_q;
`else
  logic unused_kill_cnt;
  assign unused_kill_cnt = ^kill_cnt;
`endif

endmodule

// File: tb/tb_rf_wr_port_arbiter.sv
// Scoreboard bench for rf_wr_port_arbiter: directed stimulus pushes the
// hand-computed register writes into a queue, and a monitor on the falling
// clock edge pops and compares each write the DUT presents. Protocol and
// timing points (reset values, latencies, ld_ready, stall_req) are checked
// directly. Stat counters are checked when RF_WR_ARB_STATS_EN is defined.
module tb_rf_wr_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wbWrEn;
  logic [4:0]  wbWrAddr;
  logic [31:0] wbWrVal;
  logic        ldValid;
  logic        ldReady;
  logic [4:0]  ldAddr;
  logic [31:0] ldVal;
  logic        rfWrEn;
  logic [4:0]  rfWrAddr;
  logic [31:0] rfWrVal;
  logic        stallReq;
`ifdef RF_WR_ARB_STATS_EN
  logic [31:0] statConflicts;
  logic [31:0] statKills;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t expQ[$];
  exp_t expHead;
  int   total = 0;
  int   bad   = 0;

  rf_wr_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wb_wr_en  (wbWrEn),
    .wb_wr_addr(wbWrAddr),
    .wb_wr_val (wbWrVal),
    .ld_valid  (ldValid),
    .ld_ready  (ldReady),
    .ld_addr   (ldAddr),
    .ld_val    (ldVal),
    .rf_wr_en  (rfWrEn),
    .rf_wr_addr(rfWrAddr),
    .rf_wr_val (rfWrVal),
    .stall_req (stallReq)
`ifdef RF_WR_ARB_STATS_EN
    ,
    .stat_conflicts(statConflicts),
    .stat_kills    (statKills)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rfWrEn) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_write: got addr=%0d val=%h, required no write",
                 rfWrAddr, rfWrVal);
      end else begin
        expHead = expQ.pop_front();
        if ((rfWrAddr !== expHead.addr) || (rfWrVal !== expHead.val)) begin
          bad++;
          $display("[TB] FAIL write_order: got addr=%0d val=%h, required addr=%0d val=%h",
                   rfWrAddr, rfWrVal, expHead.addr, expHead.val);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expectWrite(input logic [4:0] addr, input logic [31:0] val);
    exp_t e;
    e.addr = addr;
    e.val  = val;
    expQ.push_back(e);
  endtask

  // Drive one cycle of inputs; returns just after the capturing edge.
  task automatic applyStimulus(input logic wbEn, input logic [4:0] wbA,
                               input logic [31:0] wbV, input logic ldV,
                               input logic [4:0] ldA, input logic [31:0] ldD);
    wbWrEn   = wbEn;
    wbWrAddr = wbA;
    wbWrVal  = wbV;
    ldValid  = ldV;
    ldAddr   = ldA;
    ldVal    = ldD;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  initial begin
    wbWrEn = 0; wbWrAddr = 0; wbWrVal = 0;
    ldValid = 0; ldAddr = 0; ldVal = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_rf_wr_en", 32'(rfWrEn), 32'd0);
    checkOutput("reset_rf_wr_addr", 32'(rfWrAddr), 32'd0);
    checkOutput("reset_rf_wr_val", rfWrVal, 32'd0);
    checkOutput("reset_stall_req", 32'(stallReq), 32'd0);
    checkOutput("reset_ld_ready", 32'(ldReady), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("ld_ready_after_reset", 32'(ldReady), 32'd1);

    $display("[TB] writeback path");
    applyStimulus(1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'd0);
    checkOutput("wb_addr0_no_write", 32'(rfWrEn), 32'd0);
    expectWrite(5'd5, 32'hDEAD);
    applyStimulus(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    checkOutput("wb_latency_en", 32'(rfWrEn), 32'd1);
    checkOutput("wb_latency_addr", 32'(rfWrAddr), 32'd5);
    checkOutput("wb_latency_val", rfWrVal, 32'hDEAD);
    idleCycle();
    checkOutput("idle_en", 32'(rfWrEn), 32'd0);
    checkOutput("idle_hold_addr", 32'(rfWrAddr), 32'd5);
    checkOutput("idle_hold_val", rfWrVal, 32'hDEAD);

    $display("[TB] load on idle port");
    checkOutput("ld_ready_idle", 32'(ldReady), 32'd1);
    expectWrite(5'd7, 32'h1234);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
    checkOutput("load_n1_no_write", 32'(rfWrEn), 32'd0);
    idleCycle();
    checkOutput("load_n2_en", 32'(rfWrEn), 32'd1);
    checkOutput("load_n2_addr", 32'(rfWrAddr), 32'd7);
    checkOutput("load_n2_val", rfWrVal, 32'h1234);
    idleCycle();

    $display("[TB] conflict ordering");
    expectWrite(5'd10, 32'hA0);
    applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33);
    expectWrite(5'd11, 32'hB0);
    applyStimulus(1'b1, 5'd11, 32'hB0, 1'b1, 5'd4, 32'h44);
    expectWrite(5'd12, 32'hC0);
    expectWrite(5'd3, 32'h33);
    expectWrite(5'd4, 32'h44);
    applyStimulus(1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'd0);
    repeat (4) idleCycle();
    checkOutput("conflict_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] kill rule");
    expectWrite(5'd20, 32'h20);
    applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd9, 32'h1);
    expectWrite(5'd9, 32'h2);
    applyStimulus(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
    idleCycle();
    checkOutput("killed_pop_no_write", 32'(rfWrEn), 32'd0);
`ifdef RF_WR_ARB_STATS_EN
    checkOutput("stat_kills_one", statKills, 32'd1);
`endif
    idleCycle();
    expectWrite(5'd9, 32'h3);
    applyStimulus(1'b1, 5'd9, 32'h3, 1'b1, 5'd9, 32'h5);
    idleCycle();
    checkOutput("same_cycle_kill_no_write", 32'(rfWrEn), 32'd0);
`ifdef RF_WR_ARB_STATS_EN
    checkOutput("stat_kills_two", statKills, 32'd2);
`endif
    expectWrite(5'd21, 32'h21);
    applyStimulus(1'b1, 5'd21, 32'h21, 1'b1, 5'd0, 32'h55);
    idleCycle();
    checkOutput("load_addr0_no_write", 32'(rfWrEn), 32'd0);
    idleCycle();
    checkOutput("kill_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] full queue and starvation");
    for (int k = 0; k <= 15; k++) begin
      logic wb;
      logic ld;
      wb = (k <= 10);
      ld = (k <= 4);
      if (wb) expectWrite(5'(k + 1), 32'h100 + 32'(k));
      if (k == 10) begin
        for (int j = 0; j < 4; j++) expectWrite(5'(24 + j), 32'hA00 + 32'(j));
      end
      applyStimulus(wb, 5'(k + 1), 32'h100 + 32'(k), ld, 5'(24 + k), 32'hA00 + 32'(k));
      if (k == 3)  checkOutput("ld_ready_full", 32'(ldReady), 32'd0);
      if (k == 8)  checkOutput("stall_before_limit", 32'(stallReq), 32'd0);
      if (k == 9)  checkOutput("stall_at_limit", 32'(stallReq), 32'd1);
      if (k == 10) checkOutput("ld_ready_no_comb_pop", 32'(ldReady), 32'd0);
      if (k == 14) checkOutput("stall_hold_until_empty", 32'(stallReq), 32'd1);
      if (k == 15) checkOutput("stall_release", 32'(stallReq), 32'd0);
    end
    idleCycle();
    checkOutput("starve_drained", 32'(expQ.size()), 32'd0);
    checkOutput("ld_ready_after_drain", 32'(ldReady), 32'd1);

    $display("[TB] reset mid-drain");
    for (int k = 0; k <= 3; k++) begin
      expectWrite(5'(13 + k), 32'h300 + 32'(k));
      applyStimulus(1'b1, 5'(13 + k), 32'h300 + 32'(k), (k < 3), 5'(16 + k), 32'h400 + 32'(k));
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_rf_wr_en", 32'(rfWrEn), 32'd0);
    checkOutput("midreset_rf_wr_addr", 32'(rfWrAddr), 32'd0);
    checkOutput("midreset_rf_wr_val", rfWrVal, 32'd0);
    checkOutput("midreset_ld_ready", 32'(ldReady), 32'd0);
    wbWrEn = 0; ldValid = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) idleCycle();
    checkOutput("post_reset_ld_ready", 32'(ldReady), 32'd1);
    checkOutput("post_reset_no_writes", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wr_port_arbiter.md
Name: rf_wr_port_arbiter

Overview:
- Shares the single register-file write port between the Writeback stage and late load-data returns from the memory interface.
- Writeback writes are never stalled and always win the port.
- Load returns are buffered in a small queue and drained into idle port cycles.
- A starvation FSM requests a pipeline stall when the queue cannot drain, and a kill check stops a stale load value from overwriting a younger Writeback result.

Parameters:
REG_WIDTH, core::REG_WIDTH, register data width
RF_ADDR_WIDTH, core::RF_ADDR_WIDTH, register index width
LQ_DEPTH, 4, load-return queue entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive blocked cycles before stall request (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wb_wr_en  in  1  Writeback RF write request (no backpressure)
wb_wr_addr  in  RF_ADDR_WIDTH  Writeback destination
wb_wr_val  in  REG_WIDTH  Writeback data
ld_valid  in  1  load return valid
ld_ready  out  1  load return accepted (= !full && !rst)
ld_addr  in  RF_ADDR_WIDTH  load destination
ld_val  in  REG_WIDTH  load data
rf_wr_en  out  1  registered RF write enable
rf_wr_addr  out  RF_ADDR_WIDTH  registered RF write index
rf_wr_val  out  REG_WIDTH  registered RF write data
stall_req  out  1  registered request to freeze issue upstream

Behaviour:
- Reset is asynchronous and active-high.
- Reset values: rf_wr_en=0, rf_wr_addr=0, rf_wr_val=0, stall_req=0, queue empty, all entry valid bits 0, starvation counter 0, FSM in RUN. ld_ready=0 while rst is high.
- A reset asserted mid-operation discards all queued loads.
- Writeback path: wb_wr_en in cycle N produces rf_wr_en=1 with the same addr/val in cycle N+1.
- Load handshake: ld_valid && ld_ready in cycle N pushes {valid=1, addr, val}; the entry is at the queue head no earlier than N+1.
- Drain: in a cycle with wb_wr_en=0 and a non-empty queue, the head is popped.
  - If the head's valid bit is set, rf_wr_en=1 next cycle with the head's addr/val.
  - If the head was killed, the pop still consumes the slot and rf_wr_en=0.
- Minimum load latency: handshake in N, rf_wr_en in N+2.
- Idle cycle: if neither a Writeback write nor a queue pop occurs, rf_wr_en=0 and addr/val hold their previous values.
- Address 0 (hard-wired zero register):
  - A Writeback write to address 0 produces rf_wr_en=0.
  - A load to address 0 is enqueued with valid=0 and drains silently.
- Kill rule: the Writeback instruction is always younger in program order than any outstanding load. A wb_wr_en to addr A in cycle N clears the valid bit of every queued entry with addr A, including an entry pushed in cycle N.
- Full queue: ld_ready=0. A pop and a push in the same cycle are allowed when not full. ld_ready is not raised combinationally by a same-cycle pop.
- Pointer wrap: read and write pointers are log2(LQ_DEPTH)+1 bits; full and empty are decided by the MSB comparison.
- Starvation FSM, states RUN and STALL:
  - RUN: the counter increments each cycle in which the queue is non-empty and wb_wr_en=1, and clears on any pop or when the queue is empty. When the counter reaches STARVE_LIMIT, go to STALL; stall_req=1 from the next cycle.
  - STALL: stall_req held at 1. Upstream guarantees wb_wr_en=0 from the second cycle of stall_req onward; Writeback keeps priority if it still asserts. Exit to RUN when the queue is empty; stall_req=0 the cycle after exit and the counter clears.

Optional Feature:
- Macro: RF_WR_ARB_STATS_EN.
- Defined:
  - Adds output stat_conflicts (32 bits): saturating count of cycles with wb_wr_en=1 and a non-empty queue.
  - Adds output stat_kills (32 bits): saturating count of entries whose valid bit is cleared by the kill rule.
  - Both counters reset to 0.
- Undefined: both ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package core: add the LQ_DEPTH and STARVE_LIMIT defaults and the struct RfWrReq {valid, addr, val}.
- Sub-module rf_wr_ldq: queue storage, pointers, full/empty, and the parallel address-match kill logic.
- The arbitration, output registers and FSM live in the top module.

Test Plan:
- Writeback only: wb addr=5 val=0xDEAD in cycle 10 -> rf_wr_en=1, addr=5, val=0xDEAD in cycle 11. wb addr=0 -> rf_wr_en=0.
- Load on idle port: handshake addr=7 val=0x1234 in cycle 10 with wb idle -> rf_wr_en=1, addr=7, val=0x1234 in cycle 12.
- Conflict ordering: loads to 3 and 4 queued while wb writes every cycle for 3 cycles, then wb idle -> the load to 3 is written in the first idle+1 cycle and the load to 4 in the next, in order.
- Kill: queued load addr=9 val=0x1, then wb addr=9 val=0x2 -> RF sees only 0x2; the queue drains with no write for addr=9. With stats: stat_kills=1.
- Full and starvation, STARVE_LIMIT=8, LQ_DEPTH=4: 4 loads queued with continuous wb -> ld_ready=0; stall_req=1 nine cycles after blocking starts. Release wb -> 4 writes, then stall_req=0.
- Reset mid-drain: assert rst with 3 queued entries -> outputs zero immediately; after release no queued writes appear and ld_ready=1.
